// File: rtl/irq_cfg_sequencer.sv
// APB master that programs NO_OF_PERIPHERALS interrupt priority registers
// with a rotated priority map, with optional readback verify and timeout.
module irq_cfg_sequencer #(
  parameter int NO_OF_PERIPHERALS = 16,
  parameter int WIDTH = $clog2(NO_OF_PERIPHERALS),
  parameter int TIMEOUT = 8
) (
  input  logic             pclk,
  input  logic             preset,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic             verify_en,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [WIDTH-1:0] paddr,
  output logic [WIDTH-1:0] pwdata,
  input  logic [WIDTH-1:0] prdata,
  input  logic             pready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [WIDTH-1:0] err_addr
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, FINISH
  } state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(NO_OF_PERIPHERALS - 1);
  localparam logic [WIDTH:0] NP = (WIDTH + 1)'(NO_OF_PERIPHERALS);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic             ven_q, ven_d;
  logic [1:0]       ec_q, ec_d;
  logic [WIDTH-1:0] ea_q, ea_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] exp_data;

  assign sum = {1'b0, idx_q} + {1'b0, base_q};
  assign exp_data = WIDTH'(sum % NP);

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      base_q  <= '0;
      ven_q   <= 1'b0;
      ec_q    <= 2'b00;
      ea_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      ven_q   <= ven_d;
      ec_q    <= ec_d;
      ea_q    <= ea_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    ven_d   = ven_q;
    ec_d    = ec_q;
    ea_d    = ea_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WR_SETUP;
          idx_d   = '0;
          cnt_d   = '0;
          base_d  = base;
          ven_d   = verify_en;
          ec_d    = 2'b00;
          ea_d    = '0;
        end
      end
      WR_SETUP: begin
        cnt_d   = '0;
        state_d = WR_ACCESS;
      end
      WR_ACCESS: begin
        if (pready) begin
          if (idx_q != LAST) begin
            idx_d   = idx_q + WIDTH'(1);
            state_d = WR_SETUP;
          end else if (ven_q) begin
            idx_d   = '0;
            state_d = RD_SETUP;
          end else begin
            state_d = FINISH;
          end
        end else if (cnt_q == CMAX) begin
          ec_d    = 2'b10;
          ea_d    = idx_q;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RD_SETUP: begin
        cnt_d   = '0;
        state_d = RD_ACCESS;
      end
      RD_ACCESS: begin
        if (pready) begin
          if (prdata != exp_data) begin
            ec_d    = 2'b01;
            ea_d    = idx_q;
            state_d = FINISH;
          end else if (idx_q == LAST) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + WIDTH'(1);
            state_d = RD_SETUP;
          end
        end else if (cnt_q == CMAX) begin
          ec_d    = 2'b10;
          ea_d    = idx_q;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset drops them at once
  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    done    = 1'b0;
    unique case (state_q)
      WR_SETUP: begin
        psel   = 1'b1;
        pwrite = 1'b1;
        paddr  = idx_q;
        pwdata = exp_data;
      end
      WR_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = idx_q;
        pwdata  = exp_data;
      end
      RD_SETUP: begin
        psel  = 1'b1;
        paddr = idx_q;
      end
      RD_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        paddr   = idx_q;
      end
      FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign err_code = ec_q;
  assign err_addr = ea_q;

endmodule

// File: tb/tb_irq_cfg_sequencer.sv
// Bench for irq_cfg_sequencer: echoing APB slave with per-register wait
// states, fixed vector table, corner sequences and randomized runs.
module tb_irq_cfg_sequencer;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int TO = 8;

  logic         pclk = 1'b0;
  logic         preset = 1'b0;
  logic         start = 1'b1;
  logic [W-1:0] base = '0;
  logic         verify_en = 1'b0;
  logic         pready = 1'b0;
  logic [W-1:0] prdata = '0;
  logic         psel, penable, pwrite, busy, done;
  logic [W-1:0] paddr, pwdata, err_addr;
  logic [1:0]   err_code;

  int n_vec = 0;
  int n_bad = 0;

  int           ww[N];
  int           wr[N];
  int           c_addr = -1;
  logic [W-1:0] c_val = '0;
  logic [W-1:0] mem[N];
  int           acc = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] d;
  } xfer_t;
  xfer_t log_w[$];
  xfer_t log_r[$];

  typedef struct {
    logic [W-1:0] base;
    bit           ven;
    int           w_addr;
    int           w_len;
    bit           w_rd;
    int           c_addr;
    logic [W-1:0] c_val;
    logic [1:0]   e_code;
    logic [W-1:0] e_addr;
    int           e_cyc;
    int           e_nw;
    int           e_nr;
  } vec_t;
  vec_t tbl[7];

  irq_cfg_sequencer #(
    .NO_OF_PERIPHERALS(N),
    .WIDTH(W),
    .TIMEOUT(TO)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .start(start),
    .base(base),
    .verify_en(verify_en),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .busy(busy),
    .done(done),
    .err_code(err_code),
    .err_addr(err_addr)
  );

  always #5 pclk = ~pclk;

  // Slave: decides pready for the coming edge, logs completing transfers
  always @(negedge pclk) begin
    int w;
    if (psel && penable) begin
      w = pwrite ? ww[paddr] : wr[paddr];
      pready = (acc == w);
      acc++;
      if (pready) begin
        if (pwrite) begin
          mem[paddr] = pwdata;
          log_w.push_back('{paddr, pwdata});
        end else begin
          log_r.push_back('{paddr, pwdata});
        end
      end
    end else begin
      acc = 0;
      pready = 1'($urandom);
    end
    prdata = (int'(paddr) == c_addr) ? c_val : mem[paddr];
  end

  task automatic check(input string name, input longint act,
                       input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      ww[i] = 0;
      wr[i] = 0;
    end
    c_addr = -1;
    c_val = '0;
  endtask

  function automatic void model(input logic [W-1:0] b, input bit ven,
                                output logic [1:0] ec,
                                output logic [W-1:0] ea,
                                output int cyc, output int nw,
                                output int nr);
    ec = 2'b00;
    ea = '0;
    cyc = 1;
    nw = 0;
    nr = 0;
    for (int i = 0; i < N; i++) begin
      if (ww[i] >= TO) begin
        cyc += 1 + TO;
        ec = 2'b10;
        ea = W'(i);
        return;
      end
      cyc += 2 + ww[i];
      nw++;
    end
    if (!ven) return;
    for (int i = 0; i < N; i++) begin
      if (wr[i] >= TO) begin
        cyc += 1 + TO;
        ec = 2'b10;
        ea = W'(i);
        return;
      end
      cyc += 2 + wr[i];
      nr++;
      if (c_addr == i && c_val != W'((i + int'(b)) % N)) begin
        ec = 2'b01;
        ea = W'(i);
        return;
      end
    end
  endfunction

  task automatic run_check(input string tag, input logic [W-1:0] b,
                           input bit ven, input logic [1:0] ec,
                           input logic [W-1:0] ea, input int ecyc,
                           input int enw, input int enr);
    int cyc;
    bit ok;
    log_w.delete();
    log_r.delete();
    @(negedge pclk);
    start = 1'b1;
    base = b;
    verify_en = ven;
    @(negedge pclk);
    cyc = 1;
    check({tag, ".accept"}, busy, 1);
    while (!done && cyc < 500) begin
      start = 1'($urandom);
      base = W'($urandom);
      verify_en = 1'($urandom);
      @(negedge pclk);
      cyc++;
    end
    check({tag, ".done_seen"}, done, 1);
    check({tag, ".cycles"}, cyc, ecyc);
    check({tag, ".err_code"}, err_code, ec);
    check({tag, ".err_addr"}, err_addr, ea);
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    check({tag, ".idle"}, {busy, done, psel}, 0);
    check({tag, ".err_hold"}, {err_code, err_addr}, {ec, ea});
    check({tag, ".n_wr"}, log_w.size(), enw);
    check({tag, ".n_rd"}, log_r.size(), enr);
    ok = 1'b1;
    foreach (log_w[i])
      if (log_w[i].a != W'(i) || log_w[i].d != W'((i + int'(b)) % N))
        ok = 1'b0;
    foreach (log_r[i])
      if (log_r[i].a != W'(i) || log_r[i].d != '0) ok = 1'b0;
    check({tag, ".xfer_content"}, ok, 1);
  endtask

  initial begin
    logic [1:0]   m_ec;
    logic [W-1:0] m_ea;
    logic [W-1:0] b;
    bit           ven;
    int           m_cyc, m_nw, m_nr, cyc;
    bit           found;

    clear_cfg();
    for (int i = 0; i < N; i++) mem[i] = '0;

    repeat (3) begin
      @(negedge pclk);
      check("rst_outputs", {psel, penable, pwrite, paddr, pwdata,
                            busy, done, err_code, err_addr}, 0);
    end
    start = 1'b0;
    preset = 1'b1;
    repeat (2) @(negedge pclk);
    check("rst_no_autostart", busy, 0);

    tbl[0] = '{4'd0,  1'b1, -1, 0,  1'b0, -1, 4'd0,
               2'b00, 4'd0,  65, 16, 16};
    tbl[1] = '{4'd5,  1'b0, -1, 0,  1'b0, -1, 4'd0,
               2'b00, 4'd0,  33, 16, 0};
    tbl[2] = '{4'd0,  1'b1, 3,  20, 1'b0, -1, 4'd0,
               2'b10, 4'd3,  16, 3,  0};
    tbl[3] = '{4'd0,  1'b1, -1, 0,  1'b0, 7,  4'd0,
               2'b01, 4'd7,  49, 16, 8};
    tbl[4] = '{4'd9,  1'b1, 15, 20, 1'b1, -1, 4'd0,
               2'b10, 4'd15, 72, 16, 15};
    tbl[5] = '{4'd3,  1'b1, 2,  7,  1'b0, -1, 4'd0,
               2'b00, 4'd0,  72, 16, 16};
    tbl[6] = '{4'd15, 1'b1, -1, 0,  1'b0, -1, 4'd0,
               2'b00, 4'd0,  65, 16, 16};

    for (int v = 0; v < 7; v++) begin
      clear_cfg();
      if (tbl[v].w_addr >= 0) begin
        if (tbl[v].w_rd) wr[tbl[v].w_addr] = tbl[v].w_len;
        else ww[tbl[v].w_addr] = tbl[v].w_len;
      end
      c_addr = tbl[v].c_addr;
      c_val = tbl[v].c_val;
      run_check($sformatf("tbl%0d", v), tbl[v].base, tbl[v].ven,
                tbl[v].e_code, tbl[v].e_addr, tbl[v].e_cyc,
                tbl[v].e_nw, tbl[v].e_nr);
    end

    // start held through done: ignored in FINISH, taken in next IDLE
    clear_cfg();
    ww[0] = 20;
    @(negedge pclk);
    start = 1'b1;
    base = '0;
    verify_en = 1'b1;
    cyc = 0;
    do begin
      @(negedge pclk);
      cyc++;
    end while (!done && cyc < 100);
    check("b2b.cycles", cyc, 10);
    @(negedge pclk);
    check("b2b.done_start_ignored", busy, 0);
    @(negedge pclk);
    check("b2b.idle_start_taken", busy, 1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge pclk);
      cyc++;
    end
    check("b2b.second_done", done, 1);
    @(negedge pclk);

    // asynchronous reset in the middle of the write to register 6
    clear_cfg();
    ww[6] = 5;
    start = 1'b1;
    base = W'(2);
    verify_en = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge pclk);
      if (psel && penable && pwrite && paddr == W'(6)) begin
        found = 1'b1;
        break;
      end
    end
    check("arst.reached_addr6", found, 1);
    #2 preset = 1'b0;
    #1 check("arst.outputs_drop", {psel, penable, busy, done,
                                   paddr, pwdata, err_code}, 0);
    repeat (2) @(negedge pclk);
    check("arst.held", busy, 0);
    preset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge pclk);
    check("arst.no_autostart", busy, 0);

    for (int r = 0; r < 25; r++) begin
      b = W'($urandom);
      ven = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        ww[i] = ($urandom_range(0, 99) < 2) ? TO + int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, 3));
        wr[i] = ($urandom_range(0, 99) < 2) ? TO + int'($urandom_range(0, 3))
                                            : int'($urandom_range(0, 3));
      end
      c_addr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1))
                                           : -1;
      c_val = W'($urandom);
      model(b, ven, m_ec, m_ea, m_cyc, m_nw, m_nr);
      run_check($sformatf("rnd%0d", r), b, ven, m_ec, m_ea, m_cyc,
                m_nw, m_nr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_cfg_sequencer.md
IRQ_CFG_SEQUENCER -- requirements
Module: irq_cfg_sequencer

Interface
REQ-001 SHALL have parameter NO_OF_PERIPHERALS, default 16, number of priority registers to program.
REQ-002 SHALL have parameter WIDTH, default $clog2(NO_OF_PERIPHERALS), address/data width.
REQ-003 SHALL have parameter TIMEOUT, default 8, maximum wait-state cycles per APB transfer.
REQ-004 pclk  input  1  single clock, all logic rising-edge.
REQ-005 preset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a programming run; sampled only in IDLE.
REQ-007 base  input  WIDTH  priority rotation offset; latched on accepted start.
REQ-008 verify_en  input  1  enable readback phase; latched on accepted start.
REQ-009 psel, penable, pwrite  output  1 each  APB master controls.
REQ-010 paddr, pwdata  output  WIDTH each  APB address/write data.
REQ-011 prdata  input  WIDTH  APB read data.
REQ-012 pready  input  1  APB transfer completion.
REQ-013 busy  output  1  run in progress.
REQ-014 done  output  1  one-cycle pulse at end of every run, success or failure.
REQ-015 err_code  output  2  00 none, 01 readback mismatch, 10 timeout; holds until next accepted start.
REQ-016 err_addr  output  WIDTH  index of failing register; holds until next accepted start.

Function
REQ-017 SHALL implement FSM states IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS, FINISH.
REQ-018 IDLE: start=1 -> WR_SETUP, idx=0, latch base/verify_en, clear err_code/err_addr; start ignored in all other states.
REQ-019 WR_SETUP: psel=1, penable=0, pwrite=1, paddr=idx, pwdata=(idx+base_latched) mod NO_OF_PERIPHERALS; unconditionally -> WR_ACCESS.
REQ-020 WR_ACCESS: psel=1, penable=1, paddr/pwdata/pwrite held stable; pready=1 -> idx<N-1: idx+1, WR_SETUP; idx=N-1: verify_en ? (idx=0, RD_SETUP) : FINISH.
REQ-021 RD_SETUP/RD_ACCESS: same handshake with pwrite=0, pwdata=0; on pready=1 compare prdata to expected value for idx.
REQ-022 Readback mismatch -> err_code=01, err_addr=idx, -> FINISH immediately (remaining reads skipped).
REQ-023 Wait-state counter cleared on entering each ACCESS state, increments each ACCESS cycle with pready=0; reaching TIMEOUT -> err_code=10, err_addr=idx, -> FINISH.
REQ-024 FINISH: psel=penable=pwrite=0, done=1 for exactly one cycle, -> IDLE.
REQ-025 busy=1 in every state except IDLE; psel=0, penable=0, paddr=0, pwdata=0 in IDLE and FINISH.
REQ-026 Zero-wait-state run length: 2N cycles write, plus 2N read when verify_en=1, plus 1 FINISH cycle.
REQ-027 pready outside ACCESS states SHALL be ignored.
REQ-028 start asserted in the same cycle as done SHALL be ignored; start in the cycle after (IDLE) SHALL be accepted.

Reset
REQ-029 preset=0 SHALL asynchronously force IDLE, idx=0, counter=0, all outputs 0 (err_code=00, err_addr=0, busy=0, done=0), including mid-transfer.
REQ-030 First run after reset release SHALL require a new start sampled high at a pclk edge with preset=1.

Verification
REQ-031 Reset: preset=0 for 3 cycles with start=1 -> all outputs 0, no psel.
REQ-032 base=0, verify_en=1, pready tied 1, slave model echoes writes -> writes addr 0..15 with data 0..15, reads 0..15, done pulses at cycle 65 after start, err_code=00.
REQ-033 base=5, verify_en=0 -> pwdata addr 0=5, addr 10=15, addr 11=0, addr 15=4; done after 33 cycles; no read transfers.
REQ-034 pready held 0 during write of addr 3 -> after 8 ACCESS cycles err_code=10, err_addr=3, psel drops, done one cycle, busy drops.
REQ-035 Slave returns 0 on read of addr 7 (expected 7, base=0) -> err_code=01, err_addr=7, no read of addr 8.
REQ-036 preset=0 asserted mid-WR_ACCESS at addr 6 with start held 1 -> psel/penable/busy drop without waiting for pclk; start pulse at busy=1 in later run ignored.
